// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall control for a five-stage in-order pipeline.
// EX/MEM/WB destination state is tracked internally from the decode-stage fields.
module fwd_hazard_ctrl #(
    parameter int AW = 5,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs1,
    input  logic [AW-1:0] id_rs2,
    input  logic [AW-1:0] id_rd,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic          ex_flush,
    output logic [1:0]    fwd_a,
    output logic [1:0]    fwd_b,
    output logic          stall,
    output logic          pc_write,
    output logic          ifid_write,
    output logic [CW-1:0] stall_count
);

    localparam logic [AW-1:0] REG_ZERO = {AW{1'b0}};
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    // Nearest producer wins: MEM result first, then WB data, never for x0.
    function automatic logic [1:0] fwd_select(
        input logic [AW-1:0] src,
        input logic [AW-1:0] mem_rd,
        input logic          mem_rw,
        input logic [AW-1:0] wb_rd,
        input logic          wb_rw
    );
        logic [1:0] sel;
        if (mem_rw && (mem_rd != REG_ZERO) && (mem_rd == src)) begin
            sel = 2'b10;
        end else if (wb_rw && (wb_rd != REG_ZERO) && (wb_rd == src)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    logic [AW-1:0] ex_rs1_r, ex_rs2_r, ex_rd_r, mem_rd_r, wb_rd_r;
    logic          ex_regwrite_r, ex_memread_r;
    logic          mem_regwrite_r, mem_memread_r, wb_regwrite_r;
    logic [CW-1:0] stall_count_r;
    logic          stall_s, load_ex_s, unused_s;

    // Load-use detection; a flush squashes the consumer, so it never stalls.
    always_comb begin
        stall_s   = 1'b0;
        load_ex_s = 1'b0;
        if (ex_memread_r && (ex_rd_r != REG_ZERO) && id_valid && !ex_flush &&
            ((ex_rd_r == id_rs1) || (ex_rd_r == id_rs2))) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
        load_ex_s = id_valid && !stall_s && !ex_flush;
    end

    assign stall       = stall_s;
    assign pc_write    = ~stall_s;
    assign ifid_write  = ~stall_s;
    assign fwd_a       = fwd_select(ex_rs1_r, mem_rd_r, mem_regwrite_r, wb_rd_r, wb_regwrite_r);
    assign fwd_b       = fwd_select(ex_rs2_r, mem_rd_r, mem_regwrite_r, wb_rd_r, wb_regwrite_r);
    assign stall_count = stall_count_r;
    // The MEM load flag is kept for stage visibility; no current rule consumes it.
    assign unused_s    = mem_memread_r;

    // Stage tracker: shift EX->MEM->WB, EX takes the decode fields or a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rs1_r       <= {AW{1'b0}};
            ex_rs2_r       <= {AW{1'b0}};
            ex_rd_r        <= {AW{1'b0}};
            ex_regwrite_r  <= 1'b0;
            ex_memread_r   <= 1'b0;
            mem_rd_r       <= {AW{1'b0}};
            mem_regwrite_r <= 1'b0;
            mem_memread_r  <= 1'b0;
            wb_rd_r        <= {AW{1'b0}};
            wb_regwrite_r  <= 1'b0;
        end else begin
            wb_rd_r        <= mem_rd_r;
            wb_regwrite_r  <= mem_regwrite_r;
            mem_rd_r       <= ex_rd_r;
            mem_regwrite_r <= ex_regwrite_r;
            mem_memread_r  <= ex_memread_r;
            if (load_ex_s) begin
                ex_rs1_r      <= id_rs1;
                ex_rs2_r      <= id_rs2;
                ex_rd_r       <= id_rd;
                ex_regwrite_r <= id_regwrite;
                ex_memread_r  <= id_memread;
            end else begin
                ex_rs1_r      <= {AW{1'b0}};
                ex_rs2_r      <= {AW{1'b0}};
                ex_rd_r       <= {AW{1'b0}};
                ex_regwrite_r <= 1'b0;
                ex_memread_r  <= 1'b0;
            end
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_r <= {CW{1'b0}};
        end else if (stall_s && (stall_count_r != CNT_MAX)) begin
            stall_count_r <= stall_count_r + CW'(1);
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed pipeline scenarios plus random
// traffic against a history-list model; a CW=2 instance exercises saturation.
module tb_fwd_hazard_ctrl;
    localparam int AW   = 5;
    localparam int CW   = 16;
    localparam int CWS  = 2;
    localparam int MAXM = (1 << CW) - 1;
    localparam int MAXS = (1 << CWS) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic id_valid = 1'b0, id_regwrite = 1'b0, id_memread = 1'b0, ex_flush = 1'b0;
    logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic [1:0] fwd_a, fwd_b, s_fwd_a, s_fwd_b;
    logic stall, pc_write, ifid_write, s_stall, s_pc_write, s_ifid_write;
    logic [CW-1:0] stall_count;
    logic [CWS-1:0] s_stall_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.AW(AW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_flush(ex_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .pc_write(pc_write),
        .ifid_write(ifid_write), .stall_count(stall_count));

    fwd_hazard_ctrl #(.AW(AW), .CW(CWS)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_flush(ex_flush),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall(s_stall), .pc_write(s_pc_write),
        .ifid_write(s_ifid_write), .stall_count(s_stall_count));

    // Model: hist[0] is the instruction in EX, hist[1] in MEM, hist[2] in WB.
    typedef struct packed {
        logic [AW-1:0] rs1, rs2, rd;
        logic rw, mr;
    } ins_t;
    ins_t hist[3];
    int m_cnt = 0;

    function automatic int cap(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    function automatic logic m_stall();
        return id_valid && !ex_flush && hist[0].mr && (hist[0].rd != 0) &&
               ((hist[0].rd == id_rs1) || (hist[0].rd == id_rs2));
    endfunction

    function automatic logic [1:0] m_fwd(input logic [AW-1:0] src);
        for (int k = 1; k < 3; k++) begin
            if (hist[k].rw && (hist[k].rd != 0) && (hist[k].rd == src))
                return (k == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 3; k++) hist[k] = '0;
        m_cnt = 0;
    endtask

    task automatic m_adv();
        logic s;
        ins_t n;
        s = m_stall();
        if (s) m_cnt++;
        n = '0;
        if (id_valid && !s && !ex_flush) begin
            n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd; n.rw = id_regwrite; n.mr = id_memread;
        end
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = n;
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                         input logic [AW-1:0] rd, input logic rw, input logic mr, input logic fl);
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        id_regwrite = rw; id_memread = mr; ex_flush = fl;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        m_adv();
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        m_reset();
        #1;
        checks++; if (fwd_a !== 2'b00) begin failures++; $display("FAIL reset_fwd_a got=%b exp=00", fwd_a); end
        checks++; if (fwd_b !== 2'b00) begin failures++; $display("FAIL reset_fwd_b got=%b exp=00", fwd_b); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if ({pc_write, ifid_write} !== 2'b11) begin failures++; $display("FAIL reset_writes got=%b%b exp=11", pc_write, ifid_write); end
        checks++; if (stall_count !== 16'd0 || s_stall_count !== 2'd0) begin failures++; $display("FAIL reset_count got=%0d/%0d exp=0/0", stall_count, s_stall_count); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd2, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL first_edge_load got=%b exp=1", stall); end
        step(); step();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(); step();
    endtask

    task automatic test_alu_dep();
        drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd5, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd5, 5'd3, 5'd6, 1'b1, 1'b0, 1'b0);
        checks++; if (fwd_a !== 2'b10) begin failures++; $display("FAIL alu_fwd_mem got=%b exp=10", fwd_a); end
        step();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (fwd_a !== 2'b01) begin failures++; $display("FAIL alu_fwd_wb got=%b exp=01", fwd_a); end
        checks++; if (fwd_b !== 2'b00) begin failures++; $display("FAIL alu_fwd_b_none got=%b exp=00", fwd_b); end
        step(); step();
    endtask

    task automatic test_double_match();
        drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd1, 5'd7, 5'd9, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (fwd_b !== 2'b10) begin failures++; $display("FAIL double_mem_wins got=%b exp=10", fwd_b); end
        checks++; if (fwd_a !== 2'b00) begin failures++; $display("FAIL double_fwd_a got=%b exp=00", fwd_a); end
        step(); step();
    endtask

    task automatic test_x0();
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL x0_no_stall got=%b exp=0", stall); end
        step();
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin failures++; $display("FAIL x0_no_fwd_mem got=%b%b exp=0000", fwd_a, fwd_b); end
        step();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin failures++; $display("FAIL x0_no_fwd_wb got=%b%b exp=0000", fwd_a, fwd_b); end
        step(); step();
    endtask

    task automatic test_load_use();
        int c0;
        c0 = m_cnt;
        drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd1, 5'd3, 5'd10, 1'b1, 1'b0, 1'b0);
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", stall); end
        checks++; if ({pc_write, ifid_write} !== 2'b00) begin failures++; $display("FAIL lu_writes got=%b%b exp=00", pc_write, ifid_write); end
        step();
        drive(1'b1, 5'd1, 5'd3, 5'd10, 1'b1, 1'b0, 1'b0);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lu_one_cycle got=%b exp=0", stall); end
        checks++; if (stall_count !== CW'(c0 + 1)) begin failures++; $display("FAIL lu_count got=%0d exp=%0d", stall_count, c0 + 1); end
        step();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (fwd_b !== 2'b01) begin failures++; $display("FAIL lu_fwd_b_wb got=%b exp=01", fwd_b); end
        checks++; if (fwd_a !== 2'b00) begin failures++; $display("FAIL lu_fwd_a got=%b exp=00", fwd_a); end
        step(); step();
    endtask

    task automatic test_flush();
        int c0;
        c0 = m_cnt;
        drive(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd4, 5'd0, 5'd9, 1'b1, 1'b1, 1'b1);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flush_no_stall got=%b exp=0", stall); end
        step();
        drive(1'b1, 5'd9, 5'd0, 5'd11, 1'b1, 1'b0, 1'b0);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flush_bubble got=%b exp=0", stall); end
        checks++; if (stall_count !== CW'(c0)) begin failures++; $display("FAIL flush_count got=%0d exp=%0d", stall_count, c0); end
        step();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(); step();
    endtask

    task automatic test_back_to_back();
        int c0;
        c0 = m_cnt;
        drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0);
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL b2b_stall1 got=%b exp=1", stall); end
        step();
        drive(1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL b2b_release1 got=%b exp=0", stall); end
        step();
        drive(1'b1, 5'd4, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL b2b_stall2 got=%b exp=1", stall); end
        step();
        drive(1'b1, 5'd4, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL b2b_release2 got=%b exp=0", stall); end
        checks++; if (stall_count !== CW'(c0 + 2)) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", stall_count, c0 + 2); end
        step();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(); step();
    endtask

    task automatic test_sat_reset();
        rst_n = 1'b0;
        m_reset();
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0);
            step();
            drive(1'b1, 5'd3, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
            step();
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
            step();
        end
        checks++; if (s_stall_count !== 2'd3) begin failures++; $display("FAIL sat_count got=%0d exp=3", s_stall_count); end
        checks++; if (stall_count !== 16'd5) begin failures++; $display("FAIL wide_count got=%0d exp=5", stall_count); end
        drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd3, 5'd3, 5'd6, 1'b1, 1'b0, 1'b0);
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL pre_reset_stall got=%b exp=1", stall); end
        rst_n = 1'b0;
        m_reset();
        #1;
        checks++; if ({stall, s_stall} !== 2'b00) begin failures++; $display("FAIL async_stall got=%b%b exp=00", stall, s_stall); end
        checks++; if ({pc_write, ifid_write} !== 2'b11) begin failures++; $display("FAIL async_writes got=%b%b exp=11", pc_write, ifid_write); end
        checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin failures++; $display("FAIL async_fwd got=%b%b exp=0000", fwd_a, fwd_b); end
        checks++; if (stall_count !== 16'd0 || s_stall_count !== 2'd0) begin failures++; $display("FAIL async_count got=%0d/%0d exp=0/0", stall_count, s_stall_count); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [1:0] ea, eb;
        logic es;
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
                  AW'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 7) == 0));
            ea = m_fwd(hist[0].rs1);
            eb = m_fwd(hist[0].rs2);
            es = m_stall();
            checks++; if (fwd_a !== ea || s_fwd_a !== ea) begin failures++; $display("FAIL rnd_fwd_a cyc=%0d got=%b/%b exp=%b", i, fwd_a, s_fwd_a, ea); end
            checks++; if (fwd_b !== eb || s_fwd_b !== eb) begin failures++; $display("FAIL rnd_fwd_b cyc=%0d got=%b/%b exp=%b", i, fwd_b, s_fwd_b, eb); end
            checks++; if (stall !== es || s_stall !== es) begin failures++; $display("FAIL rnd_stall cyc=%0d got=%b/%b exp=%b", i, stall, s_stall, es); end
            checks++; if (pc_write !== !es || ifid_write !== !es || s_pc_write !== !es || s_ifid_write !== !es) begin failures++; $display("FAIL rnd_writes cyc=%0d got=%b%b exp=%b", i, pc_write, ifid_write, !es); end
            checks++; if (stall_count !== CW'(cap(m_cnt, MAXM))) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, stall_count, cap(m_cnt, MAXM)); end
            checks++; if (s_stall_count !== CWS'(cap(m_cnt, MAXS))) begin failures++; $display("FAIL rnd_sat_count cyc=%0d got=%0d exp=%0d", i, s_stall_count, cap(m_cnt, MAXS)); end
            step();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_reset();
        #1;
        test_reset();
        test_alu_dep();
        test_double_match();
        test_x0();
        test_load_use();
        test_flush();
        test_back_to_back();
        test_sat_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
